// File: rtl/neurosync_pkg.sv
// neurosync_pkg: state encodings and opcode constants shared by the NeuroSync round controller.
package neurosync_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARACAO    = 4'd1,
        ESCOLHE_MODO  = 4'd2,
        AG_CONF_MODO  = 4'd3,
        PREP_JOGO     = 4'd4,
        PREP_PERGUNTA = 4'd5,
        FAIXA_IDLE    = 4'd6,
        AG_MED_FAIXA  = 4'd7,
        AG_RESP       = 4'd8,
        ERRO          = 4'd9,
        FEEDBACK      = 4'd10,
        AG_CONF_FB    = 4'd11,
        PROXIMA       = 4'd12,
        GANHOU        = 4'd13,
        PERDEU        = 4'd14
    } estado_t;

    localparam logic [1:0] OPC_FAIXA  = 2'b11;
    localparam logic [1:0] OPC_NENHUM = 2'b00;

endpackage

// File: rtl/neurosync_contador_ciclos.sv
// neurosync_contador_ciclos: cycle counter that raises fim on the cycle its count reaches LIMITE-1.
module neurosync_contador_ciclos #(
    parameter int LIMITE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic conta,
    input  logic limpa,
    output logic fim
);

    localparam int W = $clog2(LIMITE + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= limpa ? '0 : conta ? cnt + 1'b1 : cnt;

    assign fim = conta && cnt == W'(LIMITE - 1);

endmodule

// File: rtl/neurosync_round_controller.sv
// neurosync_round_controller: NeuroSync game-flow FSM with question, idle and lives counters.
// Optional answer timeout enabled by defining NEUROSYNC_TIMEOUT_EN.
module neurosync_round_controller
    import neurosync_pkg::*;
#(
    parameter int N_PERGUNTAS    = 8,
    parameter int IDLE_CICLOS    = 1000,
    parameter int N_VIDAS        = 3,
    parameter int TIMEOUT_CICLOS = 50000,
    localparam int PW = N_PERGUNTAS > 1 ? $clog2(N_PERGUNTAS) : 1,
    localparam int VW = $clog2(N_VIDAS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          jogar_det,
    input  logic          confirma_det,
    input  logic [1:0]    opcode,
    input  logic          acertou_faixa,
    input  logic          acertou_play,
    input  logic          errou_play,
    input  logic          pronto_play,
    output logic          zera,
    output logic          registra_modo,
    output logic          zera_prep_jogo,
    output logic          set_pos,
    output logic          medir,
    output logic          enable_mov,
    output logic          show_leds_servo,
    output logic          jogando,
    output logic          win,
    output logic          lose,
    output logic [PW-1:0] pergunta_idx,
    output logic [VW-1:0] vidas,
    output logic [3:0]    estado
);

    estado_t state, nxt;
    logic fim_idle, fim_to, conta_to, ultima;

    assign ultima = pergunta_idx == PW'(N_PERGUNTAS - 1);

    neurosync_contador_ciclos #(.LIMITE(IDLE_CICLOS)) u_idle (
        .clock(clock), .reset(reset),
        .conta(state == FAIXA_IDLE), .limpa(state != FAIXA_IDLE), .fim(fim_idle)
    );

    // Without the timeout feature the counter is never enabled and fim_to stays low.
`ifdef NEUROSYNC_TIMEOUT_EN
    assign conta_to = state == AG_RESP || state == AG_MED_FAIXA;
`else
    assign conta_to = 1'b0;
`endif

    neurosync_contador_ciclos #(.LIMITE(TIMEOUT_CICLOS)) u_timeout (
        .clock(clock), .reset(reset),
        .conta(conta_to), .limpa(!conta_to), .fim(fim_to)
    );

    always_comb begin
        nxt = INICIAL;
        case (state)
            INICIAL:       nxt = jogar_det ? PREPARACAO : INICIAL;
            PREPARACAO:    nxt = ESCOLHE_MODO;
            ESCOLHE_MODO:  nxt = confirma_det ? AG_CONF_MODO : ESCOLHE_MODO;
            AG_CONF_MODO:  nxt = pronto_play ? PREP_JOGO : AG_CONF_MODO;
            PREP_JOGO:     nxt = PREP_PERGUNTA;
            PREP_PERGUNTA: nxt = opcode == OPC_FAIXA ? FAIXA_IDLE : AG_RESP;
            FAIXA_IDLE:    nxt = fim_idle ? AG_MED_FAIXA : FAIXA_IDLE;
            AG_MED_FAIXA:  nxt = acertou_faixa ? FEEDBACK : fim_to ? ERRO : AG_MED_FAIXA;
            AG_RESP:       nxt = pronto_play && acertou_play ? FEEDBACK :
                                 (pronto_play && errou_play) || fim_to ? ERRO : AG_RESP;
            ERRO:          nxt = !confirma_det ? ERRO : vidas == '0 ? PERDEU : PREP_PERGUNTA;
            FEEDBACK:      nxt = confirma_det ? AG_CONF_FB : FEEDBACK;
            AG_CONF_FB:    nxt = !pronto_play ? AG_CONF_FB : ultima ? GANHOU : PROXIMA;
            PROXIMA:       nxt = PREP_PERGUNTA;
            GANHOU:        nxt = jogar_det ? PREPARACAO : GANHOU;
            PERDEU:        nxt = jogar_det ? PREPARACAO : PERDEU;
            default:       nxt = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state        <= INICIAL;
            pergunta_idx <= '0;
            vidas        <= VW'(N_VIDAS);
        end else begin
            state <= nxt;
            if (state == PREPARACAO || state == PREP_JOGO) begin
                pergunta_idx <= '0;
                vidas        <= VW'(N_VIDAS);
            end else begin
                if (state == PROXIMA && !ultima) pergunta_idx <= pergunta_idx + 1'b1;
                // A life is lost on the edge that enters ERRO.
                if (nxt == ERRO && state != ERRO && vidas != '0) vidas <= vidas - 1'b1;
            end
        end

    assign zera            = state == PREPARACAO;
    assign registra_modo   = state == ESCOLHE_MODO;
    assign zera_prep_jogo  = state == PREP_JOGO;
    assign set_pos         = state == PREP_PERGUNTA;
    assign medir           = state == AG_MED_FAIXA;
    assign enable_mov      = opcode != OPC_NENHUM || state == ESCOLHE_MODO;
    assign show_leds_servo = state >= ESCOLHE_MODO && state <= PROXIMA && state != FEEDBACK;
    assign jogando         = state == PREP_PERGUNTA || state == FAIXA_IDLE || state == AG_MED_FAIXA ||
                             state == AG_RESP || state == PROXIMA;
    assign win             = state == GANHOU;
    assign lose            = state == PERDEU;
    assign estado          = state;

endmodule

// File: tb/tb_neurosync_round_controller.sv
// tb_neurosync_round_controller: directed self-checking bench, N_PERGUNTAS=2, IDLE_CICLOS=4, N_VIDAS=3.
module tb_neurosync_round_controller;
    import neurosync_pkg::*;

    logic       clock = 1'b0, reset;
    logic       jogar_det, confirma_det, acertou_faixa, acertou_play, errou_play, pronto_play;
    logic [1:0] opcode;
    logic       zera, registra_modo, zera_prep_jogo, set_pos, medir, enable_mov;
    logic       show_leds_servo, jogando, win, lose;
    logic [0:0] pergunta_idx;
    logic [1:0] vidas;
    logic [3:0] estado;
    int testes = 0, falhas = 0, n;

    neurosync_round_controller #(
        .N_PERGUNTAS(2), .IDLE_CICLOS(4), .N_VIDAS(3), .TIMEOUT_CICLOS(10)
    ) dut (
        .clock(clock), .reset(reset), .jogar_det(jogar_det), .confirma_det(confirma_det),
        .opcode(opcode), .acertou_faixa(acertou_faixa), .acertou_play(acertou_play),
        .errou_play(errou_play), .pronto_play(pronto_play), .zera(zera),
        .registra_modo(registra_modo), .zera_prep_jogo(zera_prep_jogo), .set_pos(set_pos),
        .medir(medir), .enable_mov(enable_mov), .show_leds_servo(show_leds_servo),
        .jogando(jogando), .win(win), .lose(lose), .pergunta_idx(pergunta_idx),
        .vidas(vidas), .estado(estado)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testes++;
        if (got !== exp) begin
            falhas++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulso_jogar();    jogar_det = 1'b1;    tick(); jogar_det = 1'b0;    endtask
    task automatic pulso_confirma(); confirma_det = 1'b1; tick(); confirma_det = 1'b0; endtask
    task automatic pulso_pronto();   pronto_play = 1'b1;  tick(); pronto_play = 1'b0;  endtask

    // From INICIAL/GANHOU/PERDEU down to PREP_PERGUNTA.
    task automatic iniciar();
        pulso_jogar();
        tick();
        pulso_confirma();
        pulso_pronto();
        tick();
    endtask

    task automatic responde(input logic ac, input logic er);
        acertou_play = ac; errou_play = er; pronto_play = 1'b1;
        tick();
        acertou_play = 1'b0; errou_play = 1'b0; pronto_play = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; jogar_det = 0; confirma_det = 0; acertou_faixa = 0;
        acertou_play = 0; errou_play = 0; pronto_play = 0; opcode = 2'd1;
        repeat (2) tick();
        verifica("rst_estado", estado, INICIAL);
        verifica("rst_idx", pergunta_idx, 0);
        verifica("rst_vidas", vidas, 3);
        verifica("rst_zera", zera, 0);
        verifica("rst_win_lose", {win, lose, jogando, show_leds_servo}, 0);
        verifica("rst_enable_mov_op1", enable_mov, 1);
        opcode = 2'd0; #1;
        verifica("rst_enable_mov_op0", enable_mov, 0);
        reset = 1'b0;
        pulso_confirma();
        verifica("inicial_ignora_confirma", estado, INICIAL);

        // Game 1: two correct answers, opcode 1
        pulso_jogar();
        verifica("preparacao", estado, PREPARACAO);
        verifica("zera", zera, 1);
        tick();
        verifica("escolhe_modo", estado, ESCOLHE_MODO);
        verifica("registra_modo", registra_modo, 1);
        verifica("enable_mov_escolhe", enable_mov, 1);
        pulso_confirma();
        tick();
        verifica("ag_conf_modo_espera", estado, AG_CONF_MODO);
        pulso_pronto();
        verifica("zera_prep_jogo", zera_prep_jogo, 1);
        opcode = 2'd1;
        tick();
        verifica("set_pos", set_pos, 1);
        verifica("jogando_prep", jogando, 1);
        tick();
        verifica("ag_resp", estado, AG_RESP);
        verifica("show_leds_resp", show_leds_servo, 1);
        pulso_jogar();
        verifica("jogar_ignorado", estado, AG_RESP);
        responde(1'b1, 1'b0);
        verifica("feedback", estado, FEEDBACK);
        verifica("show_leds_fb", show_leds_servo, 0);
        pulso_confirma();
        pulso_pronto();
        verifica("proxima", estado, PROXIMA);
        verifica("idx_proxima", pergunta_idx, 0);
        tick();
        verifica("idx_incrementado", pergunta_idx, 1);
        tick();
        responde(1'b1, 1'b1);
        verifica("prioridade_acerto", estado, FEEDBACK);
        verifica("vidas_sem_perda", vidas, 3);
        pulso_confirma();
        pulso_pronto();
        verifica("ganhou", estado, GANHOU);
        verifica("win", win, 1);
        verifica("idx_final", pergunta_idx, 1);

        // Game 2: range question with 4 idle cycles, then three wrong answers
        iniciar();
        verifica("idx_reiniciado", pergunta_idx, 0);
        opcode = 2'd3;
        tick();
        n = 0;
        while (estado == FAIXA_IDLE && n < 20) begin
            n++;
            tick();
        end
        verifica("ciclos_idle", n, 4);
        verifica("medir", medir, 1);
        repeat (2) tick();
        verifica("medir_espera", medir, 1);
        acertou_faixa = 1'b1; tick(); acertou_faixa = 1'b0;
        verifica("faixa_feedback", estado, FEEDBACK);
        verifica("medir_off", medir, 0);
        opcode = 2'd1;
        pulso_confirma();
        pulso_pronto();
        repeat (2) tick();
        responde(1'b0, 1'b1);
        verifica("erro1", estado, ERRO);
        verifica("vidas2", vidas, 2);
        pulso_confirma();
        verifica("repete_pergunta", estado, PREP_PERGUNTA);
        verifica("idx_mantido", pergunta_idx, 1);
        tick();
        responde(1'b0, 1'b1);
        verifica("vidas1", vidas, 1);
        pulso_confirma();
        tick();
        responde(1'b0, 1'b1);
        verifica("vidas0", vidas, 0);
        pulso_confirma();
        verifica("perdeu", estado, PERDEU);
        verifica("lose", lose, 1);
        pulso_jogar();
        verifica("perdeu_reinicia", estado, PREPARACAO);
        tick();
        verifica("vidas_restauradas", vidas, 3);

        // Timeout behaviour in AG_RESP
        pulso_confirma();
        pulso_pronto();
        repeat (2) tick();
        n = 0;
        while (estado == AG_RESP && n < 15) begin
            n++;
            tick();
        end
`ifdef NEUROSYNC_TIMEOUT_EN
        verifica("timeout_ciclos", n, 10);
        verifica("timeout_erro", estado, ERRO);
        verifica("timeout_vidas", vidas, 2);
`else
        verifica("sem_timeout_ciclos", n, 15);
        verifica("sem_timeout_estado", estado, AG_RESP);
        verifica("sem_timeout_vidas", vidas, 3);
`endif

        // Asynchronous reset while in FAIXA_IDLE
        reset = 1'b1; tick(); reset = 1'b0;
        iniciar();
        opcode = 2'd3;
        repeat (2) tick();
        verifica("em_faixa_idle", estado, FAIXA_IDLE);
        #2 reset = 1'b1;
        #1;
        verifica("rst_async_estado", estado, INICIAL);
        verifica("rst_async_saidas", {zera, registra_modo, zera_prep_jogo, set_pos, medir,
                                      show_leds_servo, jogando, win, lose}, 0);
        verifica("rst_async_contadores", {pergunta_idx, vidas}, 3'b011);
        tick();
        reset = 1'b0;
        tick();
        verifica("pos_reset_inicial", estado, INICIAL);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
